// File: rtl/r_format_pkg.sv
// Shared ALU opcode encoding for the R-format execute stage.
// Codes 0xB-0xF are undefined and flagged as illegal by the ALU.
package r_format_pkg;

   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'h0;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'h1;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'h2;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'h3;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'h4;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'h5;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'h6;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'h7;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'h8;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'h9;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'hA;

endpackage

// File: rtl/r_format_exec_pipe_if.sv
// Instruction-in / result-out handshake bundle of the execute stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid & ready are both 1.
interface r_format_exec_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic                                in_valid;
   logic                                in_ready;
   logic [ADDR_W-1:0]                   in_rs;
   logic [ADDR_W-1:0]                   in_rt;
   logic [ADDR_W-1:0]                   in_rd;
   logic [r_format_pkg::ALU_CTRL_W-1:0] in_alu_ctrl;

   logic                                out_valid;
   logic                                out_ready;
   logic [ADDR_W-1:0]                   out_rd;
   logic [DATA_W-1:0]                   out_result;
   logic                                out_ovf;
   logic                                out_illegal;

   modport master (
      output in_valid, in_rs, in_rt, in_rd, in_alu_ctrl, out_ready,
      input  in_ready, out_valid, out_rd, out_result, out_ovf, out_illegal
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, in_alu_ctrl, out_ready,
      output in_ready, out_valid, out_rd, out_result, out_ovf, out_illegal
   );

endinterface

// File: rtl/reg_file_mp.sv
// Register array with async read ports A/B/debug and two write ports (commit beats init).
// With ZERO_REG set, entry 0 always reads 0 and ignores writes.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              cm_we,
   input  logic [ADDR_W-1:0] cm_addr,
   input  logic [DATA_W-1:0] cm_data,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Commit is applied after init so it overwrites a same-index init write.
   always_comb begin
      mem_d = mem_q;
      if (init_we) mem_d[init_addr] = init_data;
      if (cm_we)   mem_d[cm_addr]   = cm_data;
      if (ZERO_REG != 0) mem_d[0] = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      ra_data  = mem_q[ra_addr];
      rb_data  = mem_q[rb_addr];
      dbg_data = mem_q[dbg_addr];
      if (ZERO_REG != 0) begin
         if (ra_addr == '0)  ra_data  = '0;
         if (rb_addr == '0)  rb_data  = '0;
         if (dbg_addr == '0) dbg_data = '0;
      end
   end

endmodule

// File: rtl/r_format_exec_pipe.sv
// R-format execute stage: register file read with bypass from the held result, ALU,
// and a 1-deep output register whose handshake is the commit (write-back) point.
module r_format_exec_pipe
   import r_format_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                reset,
   r_format_exec_pipe_if.slave bus,
   input  logic                init_we,
   input  logic [ADDR_W-1:0]   init_addr,
   input  logic [DATA_W-1:0]   init_data,
   input  logic [ADDR_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   logic              out_valid_q,   out_valid_d;
   logic [ADDR_W-1:0] out_rd_q,      out_rd_d;
   logic [DATA_W-1:0] out_result_q,  out_result_d;
   logic              out_ovf_q,     out_ovf_d;
   logic              out_illegal_q, out_illegal_d;

   logic              accept, commit, byp_ok;
   logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;
   logic [DATA_W-1:0] sum, diff, alu_res;
   logic [SH_W-1:0]   shamt;
   logic              alu_ovf, alu_ill;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign commit       = out_valid_q && bus.out_ready;

   reg_file_mp #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_rf (
      .clk       (clk),
      .reset     (reset),
      .ra_addr   (bus.in_rs),
      .ra_data   (rf_a),
      .rb_addr   (bus.in_rt),
      .rb_data   (rf_b),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .cm_we     (commit),
      .cm_addr   (out_rd_q),
      .cm_data   (out_result_q),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   // The held result is forwarded only when it targets a real register.
   assign byp_ok = out_valid_q && !((ZERO_REG != 0) && (out_rd_q == '0));

   always_comb begin
      op_a = rf_a;
      op_b = rf_b;
      if (byp_ok && (bus.in_rs == out_rd_q)) op_a = out_result_q;
      if (byp_ok && (bus.in_rt == out_rd_q)) op_b = out_result_q;
   end

   assign sum   = op_a + op_b;
   assign diff  = op_a - op_b;
   assign shamt = op_b[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (bus.in_alu_ctrl)
         ALU_ADD: begin
            alu_res = sum;
            alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
         end
         ALU_SUB: begin
            alu_res = diff;
            alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
         end
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_NOR:  alu_res = ~(op_a | op_b);
         ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  alu_res = op_a << shamt;
         ALU_SRL:  alu_res = op_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
         default:  alu_ill = 1'b1;
      endcase
   end

   // A new accept refills the slot in the same edge that commits the old result.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_rd_d      = out_rd_q;
      out_result_d  = out_result_q;
      out_ovf_d     = out_ovf_q;
      out_illegal_d = out_illegal_q;
      if (commit) out_valid_d = 1'b0;
      if (accept) begin
         out_valid_d   = 1'b1;
         out_rd_d      = bus.in_rd;
         out_result_d  = alu_res;
         out_ovf_d     = alu_ovf;
         out_illegal_d = alu_ill;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q   <= 1'b0;
         out_rd_q      <= '0;
         out_result_q  <= '0;
         out_ovf_q     <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_rd_q      <= out_rd_d;
         out_result_q  <= out_result_d;
         out_ovf_q     <= out_ovf_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_rd      = out_rd_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_ovf     = out_ovf_q;
   assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_r_format_exec_pipe.sv
// Directed bench for r_format_exec_pipe: a 32-bit/32-reg instance and a 16-bit/8-reg instance
// share clock and reset; inputs change and outputs are sampled on the falling edge.
module tb_r_format_exec_pipe;
   import r_format_pkg::*;

   logic clk;
   logic reset;

   r_format_exec_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus32 ();
   r_format_exec_pipe_if #(.DATA_W(16), .ADDR_W(3)) bus16 ();

   logic        init_we32, init_we16;
   logic [4:0]  init_addr32, dbg_addr32;
   logic [2:0]  init_addr16, dbg_addr16;
   logic [31:0] init_data32, dbg_data32;
   logic [15:0] init_data16, dbg_data16;

   int n_tests = 0;
   int n_fail  = 0;

   r_format_exec_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut32 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus32),
      .init_we   (init_we32),
      .init_addr (init_addr32),
      .init_data (init_data32),
      .dbg_addr  (dbg_addr32),
      .dbg_data  (dbg_data32)
   );

   r_format_exec_pipe #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut16 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus16),
      .init_we   (init_we16),
      .init_addr (init_addr16),
      .init_data (init_data16),
      .dbg_addr  (dbg_addr16),
      .dbg_data  (dbg_data16)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive32(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt);
      bus32.in_valid    = 1'b1;
      bus32.in_alu_ctrl = op;
      bus32.in_rd       = rd;
      bus32.in_rs       = rs;
      bus32.in_rt       = rt;
   endtask

   task automatic drive16(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt);
      bus16.in_valid    = 1'b1;
      bus16.in_alu_ctrl = op;
      bus16.in_rd       = rd;
      bus16.in_rs       = rs;
      bus16.in_rt       = rt;
   endtask

   task automatic init32(input logic [4:0] a, input logic [31:0] d);
      init_we32 = 1'b1; init_addr32 = a; init_data32 = d;
      step();
      init_we32 = 1'b0;
   endtask

   task automatic init16(input logic [2:0] a, input logic [15:0] d);
      init_we16 = 1'b1; init_addr16 = a; init_data16 = d;
      step();
      init_we16 = 1'b0;
   endtask

   task automatic dbg32(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_addr32 = a;
      #1;
      check(tag, dbg_data32, exp);
   endtask

   task automatic dbg16(input string tag, input logic [2:0] a, input logic [15:0] exp);
      dbg_addr16 = a;
      #1;
      check(tag, {16'h0, dbg_data16}, {16'h0, exp});
   endtask

   // boundary vectors for the 32-bit instance: op, rs, rt, result, ovf, illegal
   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] res;
      logic        ovf;
      logic        ill;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // r10=0x7FFFFFFF r11=1 r12=0xFFFFFFFF r13=0x80000000 r14=31
      vecs[0]  = '{ALU_ADD,  5'd10, 5'd11, 32'h8000_0000, 1'b1, 1'b0};
      vecs[1]  = '{ALU_SLT,  5'd12, 5'd11, 32'h0000_0001, 1'b0, 1'b0};
      vecs[2]  = '{ALU_SLTU, 5'd12, 5'd11, 32'h0000_0000, 1'b0, 1'b0};
      vecs[3]  = '{ALU_SRA,  5'd13, 5'd14, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[4]  = '{4'hF,     5'd10, 5'd11, 32'h0000_0000, 1'b0, 1'b1};
      vecs[5]  = '{ALU_SUB,  5'd13, 5'd11, 32'h7FFF_FFFF, 1'b1, 1'b0};
      vecs[6]  = '{ALU_SUB,  5'd11, 5'd12, 32'h0000_0002, 1'b0, 1'b0};
      vecs[7]  = '{ALU_NOR,  5'd13, 5'd12, 32'h0000_0000, 1'b0, 1'b0};
      vecs[8]  = '{ALU_SLL,  5'd11, 5'd14, 32'h8000_0000, 1'b0, 1'b0};
      vecs[9]  = '{ALU_SRL,  5'd13, 5'd14, 32'h0000_0001, 1'b0, 1'b0};
      vecs[10] = '{ALU_AND,  5'd12, 5'd13, 32'h8000_0000, 1'b0, 1'b0};
      vecs[11] = '{ALU_ADD,  5'd12, 5'd12, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[12] = '{4'hB,     5'd12, 5'd13, 32'h0000_0000, 1'b0, 1'b1};
   end

   initial begin
      reset = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_rs = '0; bus32.in_rt = '0; bus32.in_rd = '0;
      bus32.in_alu_ctrl = '0; bus32.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.in_rs = '0; bus16.in_rt = '0; bus16.in_rd = '0;
      bus16.in_alu_ctrl = '0; bus16.out_ready = 1'b1;
      init_we32 = 1'b0; init_addr32 = '0; init_data32 = '0; dbg_addr32 = '0;
      init_we16 = 1'b0; init_addr16 = '0; init_data16 = '0; dbg_addr16 = '0;

      // reset state
      step();
      check("rst_out_valid", bus32.out_valid, 0);
      check("rst_out_result", bus32.out_result, 0);
      check("rst_out_rd", bus32.out_rd, 0);
      check("rst_in_ready", bus32.in_ready, 1);
      reset = 1'b1;
      step();

      // basic add with write-back
      init32(5'd1, 32'd1);
      init32(5'd2, 32'd2);
      drive32(ALU_ADD, 5'd3, 5'd1, 5'd2);
      step();
      bus32.in_valid = 1'b0;
      check("add_valid", bus32.out_valid, 1);
      check("add_result", bus32.out_result, 3);
      check("add_rd", bus32.out_rd, 3);
      check("add_ovf", bus32.out_ovf, 0);
      dbg32("add_r3_before_commit", 5'd3, 32'd0);
      step();
      check("add_valid_clear", bus32.out_valid, 0);
      dbg32("add_r3_after_commit", 5'd3, 32'd3);

      // back-to-back dependent instructions (rs and rt bypass)
      init32(5'd3, 32'd100);
      drive32(ALU_ADD, 5'd3, 5'd1, 5'd2);
      step();
      check("b2b_first", bus32.out_result, 3);
      drive32(ALU_SUB, 5'd4, 5'd3, 5'd1);
      step();
      check("b2b_bypass_rs", bus32.out_result, 2);
      check("b2b_rd", bus32.out_rd, 4);
      drive32(ALU_ADD, 5'd7, 5'd1, 5'd1);
      step();
      drive32(ALU_XOR, 5'd8, 5'd1, 5'd7);
      step();
      check("b2b_bypass_rt", bus32.out_result, 3);
      bus32.in_valid = 1'b0;
      step();
      dbg32("b2b_r4", 5'd4, 32'd2);
      dbg32("b2b_r3", 5'd3, 32'd3);
      dbg32("b2b_r8", 5'd8, 32'd3);

      // backpressure: held result stable, offered instruction not taken
      bus32.out_ready = 1'b0;
      drive32(ALU_ADD, 5'd3, 5'd2, 5'd2);
      step();
      drive32(ALU_OR, 5'd9, 5'd1, 5'd2);
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", bus32.in_ready, 0);
         check("bp_result", bus32.out_result, 4);
         check("bp_rd", bus32.out_rd, 3);
         dbg32("bp_r3_unchanged", 5'd3, 32'd3);
         step();
      end
      bus32.out_ready = 1'b1;
      step();
      bus32.in_valid = 1'b0;
      check("bp_next_result", bus32.out_result, 3);
      check("bp_next_rd", bus32.out_rd, 9);
      dbg32("bp_r3_committed", 5'd3, 32'd4);
      step();
      check("bp_drained", bus32.out_valid, 0);
      dbg32("bp_r9", 5'd9, 32'd3);

      // ALU boundaries
      init32(5'd10, 32'h7FFF_FFFF);
      init32(5'd11, 32'h0000_0001);
      init32(5'd12, 32'hFFFF_FFFF);
      init32(5'd13, 32'h8000_0000);
      init32(5'd14, 32'd31);
      for (int i = 0; i < 13; i++) begin
         drive32(vecs[i].op, 5'd15, vecs[i].rs, vecs[i].rt);
         step();
         check($sformatf("vec%0d_result", i), bus32.out_result, vecs[i].res);
         check($sformatf("vec%0d_ovf", i), bus32.out_ovf, vecs[i].ovf);
         check($sformatf("vec%0d_illegal", i), bus32.out_illegal, vecs[i].ill);
      end

      // zero register: write to r0 dropped, r0 never bypassed
      drive32(ALU_ADD, 5'd0, 5'd1, 5'd2);
      step();
      check("zr_result", bus32.out_result, 3);
      drive32(ALU_ADD, 5'd16, 5'd0, 5'd1);
      step();
      check("zr_no_bypass", bus32.out_result, 1);
      bus32.in_valid = 1'b0;
      step();
      dbg32("zr_r0_commit", 5'd0, 32'd0);
      dbg32("zr_r16", 5'd16, 32'd1);
      dbg32("vec_last_r15", 5'd15, 32'd0);
      init32(5'd0, 32'd55);
      dbg32("zr_r0_init", 5'd0, 32'd0);

      // init and commit to the same index on the same edge
      drive32(ALU_ADD, 5'd17, 5'd1, 5'd2);
      step();
      bus32.in_valid = 1'b0;
      init32(5'd17, 32'hAA);
      dbg32("init_vs_commit", 5'd17, 32'd3);

      // reset while a result is held
      bus32.out_ready = 1'b0;
      drive32(ALU_ADD, 5'd18, 5'd1, 5'd2);
      step();
      bus32.in_valid = 1'b0;
      check("rst2_held", bus32.out_valid, 1);
      #2 reset = 1'b0;
      #1;
      check("rst2_valid", bus32.out_valid, 0);
      check("rst2_result", bus32.out_result, 0);
      check("rst2_rd", bus32.out_rd, 0);
      dbg32("rst2_r1", 5'd1, 32'd0);
      step();
      reset = 1'b1;
      bus32.out_ready = 1'b1;
      step();
      dbg32("rst2_no_writeback", 5'd18, 32'd0);
      check("rst2_in_ready", bus32.in_ready, 1);

      // 16-bit / 8-register instance
      init16(3'd1, 16'h7FFF);
      init16(3'd2, 16'h0001);
      init16(3'd5, 16'd15);
      init16(3'd7, 16'h1234);
      drive16(ALU_ADD, 3'd3, 3'd1, 3'd2);
      step();
      check("w16_add", {16'h0, bus16.out_result}, 32'h8000);
      check("w16_add_ovf", bus16.out_ovf, 1);
      drive16(ALU_SUB, 3'd4, 3'd3, 3'd2);
      step();
      check("w16_sub_bypass", {16'h0, bus16.out_result}, 32'h7FFF);
      check("w16_sub_ovf", bus16.out_ovf, 1);
      drive16(ALU_SRA, 3'd6, 3'd3, 3'd5);
      step();
      check("w16_sra", {16'h0, bus16.out_result}, 32'hFFFF);
      drive16(4'hC, 3'd7, 3'd1, 3'd2);
      step();
      check("w16_ill_result", {16'h0, bus16.out_result}, 0);
      check("w16_ill_flag", bus16.out_illegal, 1);
      bus16.in_valid = 1'b0;
      step();
      dbg16("w16_r4", 3'd4, 16'h7FFF);
      dbg16("w16_r7_ill_commit", 3'd7, 16'h0000);
      bus16.out_ready = 1'b0;
      drive16(ALU_ADD, 3'd3, 3'd1, 3'd2);
      step();
      bus16.in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("w16_rst_valid", bus16.out_valid, 0);
      check("w16_rst_result", {16'h0, bus16.out_result}, 0);
      dbg16("w16_rst_r1", 3'd1, 16'h0000);
      step();
      reset = 1'b1;
      bus16.out_ready = 1'b1;
      step();
      dbg16("w16_rst_r3", 3'd3, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
